// File: rtl/rv2t_stage_sequencer.sv
// rtl/rv2t_stage_sequencer.sv - multi-cycle fetch/decode/execute/memory/write-back sequencer for the RV2T core
//
// Steps one instruction at a time through the core stages by pulsing the
// per-stage enables. Handles traps (illegal instruction, memory fault,
// fetch timeout, interrupt), parks on WFI and counts retired instructions.
//
// Ports:
//   clk, reset_n                   core clock, asynchronous active-low reset
//   sync_reset                     synchronous reset back to S_IDLE
//   start                          boot pulse, honoured only in S_IDLE
//   fetch_done                     instruction word valid from fetch unit
//   ctl_LOAD/STORE/WFI/MRET        decoder controls, sampled in S_EXEC
//   exception_illegal_instruction  decoder illegal flag, sampled in S_EXEC
//   mem_done, mem_error            load/store completion and fault
//   interrupt_pending, mie         interrupt request and global enable
//   fetch_enable .. trap_enable    one-cycle stage enables (registered)
//   trap_cause                     cause of the most recent trap
//   wfi_active                     high while parked in S_WFI
//   instret                        retired-instruction counter

module rv2t_stage_sequencer #(
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sync_reset,
  input  logic        start,
  input  logic        fetch_done,
  input  logic        ctl_LOAD,
  input  logic        ctl_STORE,
  input  logic        ctl_WFI,
  input  logic        ctl_MRET,
  input  logic        exception_illegal_instruction,
  input  logic        mem_done,
  input  logic        mem_error,
  input  logic        interrupt_pending,
  input  logic        mie,
  output logic        fetch_enable,
  output logic        decode_enable,
  output logic        exe_enable,
  output logic        mem_enable,
  output logic        wb_enable,
  output logic        trap_enable,
  output logic [3:0]  trap_cause,
  output logic        wfi_active,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP,
    S_WFI
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(FETCH_TIMEOUT);

  localparam logic [3:0] CAUSE_FETCH_FAULT = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;
  localparam logic [3:0] CAUSE_INTERRUPT   = 4'd11;

  state_t     state;
  logic [7:0] fetch_cnt;
  logic       mem_is_store;  // remembers load vs store for the fault cause

  // MRET needs no special sequencing: it retires through S_WB like an ALU op.
  logic unused_mret;
  assign unused_mret = ctl_MRET;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      fetch_cnt     <= 8'd0;
      mem_is_store  <= 1'b0;
      fetch_enable  <= 1'b0;
      decode_enable <= 1'b0;
      exe_enable    <= 1'b0;
      mem_enable    <= 1'b0;
      wb_enable     <= 1'b0;
      trap_enable   <= 1'b0;
      trap_cause    <= 4'd0;
      wfi_active    <= 1'b0;
      instret       <= 32'd0;
    end else if (sync_reset) begin
      state         <= S_IDLE;
      fetch_cnt     <= 8'd0;
      mem_is_store  <= 1'b0;
      fetch_enable  <= 1'b0;
      decode_enable <= 1'b0;
      exe_enable    <= 1'b0;
      mem_enable    <= 1'b0;
      wb_enable     <= 1'b0;
      trap_enable   <= 1'b0;
      trap_cause    <= 4'd0;
      wfi_active    <= 1'b0;
      instret       <= 32'd0;
    end else begin
      // Enables are pulses: cleared every cycle unless a transition sets them.
      fetch_enable  <= 1'b0;
      decode_enable <= 1'b0;
      exe_enable    <= 1'b0;
      mem_enable    <= 1'b0;
      wb_enable     <= 1'b0;
      trap_enable   <= 1'b0;
      wfi_active    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_FETCH;
            fetch_enable <= 1'b1;
            fetch_cnt    <= 8'd0;
          end
        end

        S_FETCH: begin
          // fetch_enable is high only in the entry cycle, so it doubles as
          // the "ignore fetch_done" flag. A fetch_done landing in the same
          // cycle the counter reaches the limit wins over the timeout.
          if (!fetch_enable && fetch_done) begin
            state         <= S_DECODE;
            decode_enable <= 1'b1;
          end else if (fetch_cnt + 8'd1 == TIMEOUT) begin
            fetch_cnt   <= fetch_cnt + 8'd1;
            state       <= S_TRAP;
            trap_enable <= 1'b1;
            trap_cause  <= CAUSE_FETCH_FAULT;
          end else begin
            fetch_cnt <= fetch_cnt + 8'd1;
          end
        end

        S_DECODE: begin
          state      <= S_EXEC;
          exe_enable <= 1'b1;
        end

        S_EXEC: begin
          if (exception_illegal_instruction) begin
            state       <= S_TRAP;
            trap_enable <= 1'b1;
            trap_cause  <= CAUSE_ILLEGAL;
          end else if (ctl_LOAD || ctl_STORE) begin
            state        <= S_MEM;
            mem_enable   <= 1'b1;
            mem_is_store <= !ctl_LOAD;
          end else if (ctl_WFI) begin
            state      <= S_WFI;
            wfi_active <= 1'b1;
          end else begin
            state     <= S_WB;
            wb_enable <= 1'b1;
          end
        end

        S_MEM: begin
          if (mem_done) begin
            if (mem_error) begin
              state       <= S_TRAP;
              trap_enable <= 1'b1;
              trap_cause  <= mem_is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
            end else begin
              state     <= S_WB;
              wb_enable <= 1'b1;
            end
          end
        end

        S_WB: begin
          instret <= instret + 32'd1;
          if (interrupt_pending && mie) begin
            state       <= S_TRAP;
            trap_enable <= 1'b1;
            trap_cause  <= CAUSE_INTERRUPT;
          end else begin
            state        <= S_FETCH;
            fetch_enable <= 1'b1;
            fetch_cnt    <= 8'd0;
          end
        end

        S_TRAP: begin
          state        <= S_FETCH;
          fetch_enable <= 1'b1;
          fetch_cnt    <= 8'd0;
        end

        S_WFI: begin
          // Wake on any pending interrupt; S_WB decides whether to trap.
          if (interrupt_pending) begin
            state     <= S_WB;
            wb_enable <= 1'b1;
          end else begin
            wfi_active <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
